// File: rtl/zbuffer_scanout.sv
// Scan-out reader for the z-buffered frame store: sweeps every pixel address once per frame,
// streams {x,y,color} on a valid/ready port and clears the depth RAM to far in step with the reads.
module zbuffer_scanout #(
    parameter int SIZE        = 64,
    parameter int WIDTH       = 6,
    parameter int COLOR_WIDTH = 10,
    parameter int CLEAR_DEPTH = 2**WIDTH - 1,
    localparam int AW         = $clog2(SIZE*SIZE),
    localparam int XW         = $clog2(SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    output logic                   color_rd,
    output logic [AW-1:0]          color_addr,
    input  logic [COLOR_WIDTH-1:0] color_data,
    output logic                   depth_we,
    output logic [AW-1:0]          depth_addr,
    output logic [WIDTH-1:0]       depth_din,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic [XW-1:0]          pixel_x,
    output logic [XW-1:0]          pixel_y,
    output logic [COLOR_WIDTH-1:0] pixel_color,
    output logic                   pixel_last,
    output logic                   busy,
    output logic                   frame_done
);

    localparam logic [AW-1:0]    LAST_ADDR = AW'(SIZE*SIZE - 1);
    localparam logic [WIDTH-1:0] CLEAR_VAL = WIDTH'(CLEAR_DEPTH);
    localparam int               TW        = 2*XW + 1;
    localparam int               EW        = TW + COLOR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 p1_v_q, p1_v_d, p2_v_q, p2_v_d;
    logic [TW-1:0]        p1_tag_q, p1_tag_d, p2_tag_q, p2_tag_d;
    logic [3:0][EW-1:0]   fifo_q, fifo_d;
    logic [1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]           count_q, count_d;

    logic [2:0]           credit_s;
    logic                 issue_s, push_s, pop_s, drained_s;

    // Issue credits and sequencing of the sweep.
    always_comb begin
        credit_s  = {2'b00, p1_v_q} + {2'b00, p2_v_q} + count_q;
        issue_s   = (state_q == SCAN) && (credit_s < 3'd4);
        push_s    = p2_v_q;
        pop_s     = (count_q != 3'd0) && pixel_ready;
        drained_s = (state_q == DRAIN) && !p1_v_q && !p2_v_q && (count_q == 3'd0);

        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = SCAN;
                    addr_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (issue_s && (addr_q == LAST_ADDR)) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                end else if (issue_s) begin
                    addr_d  = addr_q + AW'(1);
                end else begin
                    addr_d  = addr_q;
                end
            end
            DRAIN: begin
                if (drained_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // Two-stage tag pipe matching the RAM latency, then the 4-entry output FIFO.
    always_comb begin
        p1_v_d   = issue_s;
        p1_tag_d = {addr_q[XW-1:0], addr_q[AW-1:XW], addr_q == LAST_ADDR};
        p2_v_d   = p1_v_q;
        p2_tag_d = p1_tag_q;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = {p2_tag_q, color_data};
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {2'b00, push_s} - {2'b00, pop_s};
    end

    // State registers; reset abandons any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            p1_v_q   <= 1'b0;
            p2_v_q   <= 1'b0;
            p1_tag_q <= '0;
            p2_tag_q <= '0;
            fifo_q   <= '0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            p1_v_q   <= p1_v_d;
            p2_v_q   <= p2_v_d;
            p1_tag_q <= p1_tag_d;
            p2_tag_q <= p2_tag_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign color_rd    = issue_s;
    assign color_addr  = addr_q;
    assign depth_we    = issue_s;
    assign depth_addr  = addr_q;
    assign depth_din   = CLEAR_VAL;
    assign pixel_valid = (count_q != 3'd0);
    assign {pixel_x, pixel_y, pixel_last, pixel_color} = fifo_q[rd_ptr_q];
    assign busy        = (state_q != IDLE);
    assign frame_done  = drained_s;

endmodule

// File: tb/tb_zbuffer_scanout.sv
// Scoreboard bench for zbuffer_scanout at SIZE=4 with behavioural color and depth RAM models.
module tb_zbuffer_scanout;

    localparam int SIZE = 4;
    localparam int WIDTH = 6;
    localparam int CW = 10;
    localparam int AW = 4;
    localparam int XW = 2;
    localparam int NPIX = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          color_rd;
    logic [AW-1:0] color_addr;
    logic [CW-1:0] color_data = '0;
    logic          depth_we;
    logic [AW-1:0] depth_addr;
    logic [WIDTH-1:0] depth_din;
    logic          pixel_valid;
    logic          pixel_ready = 1'b1;
    logic [XW-1:0] pixel_x, pixel_y;
    logic [CW-1:0] pixel_color;
    logic          pixel_last;
    logic          busy;
    logic          frame_done;

    zbuffer_scanout #(.SIZE(SIZE), .WIDTH(WIDTH), .COLOR_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .color_rd(color_rd), .color_addr(color_addr), .color_data(color_data),
        .depth_we(depth_we), .depth_addr(depth_addr), .depth_din(depth_din),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
        .pixel_last(pixel_last), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic [CW-1:0] c;
        logic          last;
    } pix_t;

    pix_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int issued = 0, xferred = 0, done_cnt = 0, outstanding = 0;
    int first_rd = 0, last_rd = 0, first_vld = 0;
    logic preload = 1'b0;

    logic [CW-1:0]    cmem [NPIX];
    logic [WIDTH-1:0] dmem [NPIX];
    logic [CW-1:0]    rd_s1 = '0;

    // Color RAM with two-cycle read latency, depth RAM with write port and random preload.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (color_rd) rd_s1 <= cmem[color_addr];
        color_data <= rd_s1;
        if (preload) begin
            for (int i = 0; i < NPIX; i++) dmem[i] <= WIDTH'($urandom_range(0, 62));
        end else if (depth_we) begin
            dmem[depth_addr] <= depth_din;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_frame();
        pix_t e;
        for (int a = 0; a < NPIX; a++) begin
            e.x = XW'(a % SIZE);
            e.y = XW'(a / SIZE);
            e.c = cmem[a];
            e.last = (a == NPIX - 1);
            exp_q.push_back(e);
        end
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        bit got;
        base = done_cnt;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt > base) begin
                got = 1'b1;
                break;
            end
        end
        check("frame_done_seen", int'(got), 1);
    endtask

    // Monitor: pops the scoreboard on every transfer and watches the handshake and clear port.
    initial begin
        pix_t e;
        logic pv_prev, pr_prev, rd_prev;
        logic [14:0] prev_word;
        pv_prev = 1'b0; pr_prev = 1'b0; rd_prev = 1'b0; prev_word = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv_prev = 1'b0; rd_prev = 1'b0; outstanding = 0;
                continue;
            end
            if (color_rd) begin
                issued++;
                outstanding++;
                if (!rd_prev) first_rd = cyc;
                last_rd = cyc;
            end
            if (color_rd || depth_we) begin
                check("we_eq_rd", int'(depth_we), int'(color_rd));
                check("waddr_eq_raddr", int'(depth_addr), int'(color_addr));
            end
            if (pixel_valid && !pv_prev) first_vld = cyc;
            if (pv_prev && !pr_prev) begin
                check("stall_valid", int'(pixel_valid), 1);
                check("stall_data", int'({pixel_x, pixel_y, pixel_color, pixel_last}), int'(prev_word));
            end
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_x", int'(pixel_x), int'(e.x));
                    check("pix_y", int'(pixel_y), int'(e.y));
                    check("pix_color", int'(pixel_color), int'(e.c));
                    check("pix_last", int'(pixel_last), int'(e.last));
                end
                xferred++;
                outstanding--;
            end
            if (color_rd) check("credit_bound", int'(outstanding <= 4), 1);
            if (frame_done) done_cnt++;
            pv_prev = pixel_valid;
            pr_prev = pixel_ready;
            rd_prev = color_rd;
            prev_word = {pixel_x, pixel_y, pixel_color, pixel_last};
        end
    end

    // Directed stimulus.
    initial begin
        int bi, bx, bd;
        bit got;
        for (int a = 0; a < NPIX; a++) cmem[a] = CW'(3 * a);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_color_rd", int'(color_rd), 0);
        check("rst_depth_we", int'(depth_we), 0);
        check("rst_valid", int'(pixel_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_addr", int'(color_addr), 0);
        check("rst_pixel", int'({pixel_x, pixel_y, pixel_color, pixel_last}), 0);
        check("rst_depth_din", int'(depth_din), 63);
        @(posedge clk); #1 rst = 1'b0; preload = 1'b1;
        @(posedge clk); #1 preload = 1'b0;

        // Full-rate sweep with depth clear.
        bi = issued; bx = xferred; bd = done_cnt;
        start_frame();
        wait_done(100);
        repeat (4) @(negedge clk);
        check("t1_issued", issued - bi, 16);
        check("t1_rd_consecutive", last_rd - first_rd, 15);
        check("t1_first_valid_lat", first_vld - first_rd, 3);
        check("t1_xferred", xferred - bx, 16);
        check("t1_done_once", done_cnt - bd, 1);
        check("t1_queue_empty", exp_q.size(), 0);
        for (int a = 0; a < NPIX; a++) check("t2_depth_cleared", int'(dmem[a]), 63);

        // Random backpressure.
        for (int a = 0; a < NPIX; a++) cmem[a] = CW'(1000 - 7 * a);
        bx = xferred; bd = done_cnt;
        start_frame();
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1 pixel_ready = 1'($urandom_range(0, 1));
            if (done_cnt > bd) begin
                got = 1'b1;
                break;
            end
        end
        check("t3_done_seen", int'(got), 1);
        pixel_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_xferred", xferred - bx, 16);
        check("t3_queue_empty", exp_q.size(), 0);

        // Ready held low: issue stalls after the credits are used up.
        for (int a = 0; a < NPIX; a++) cmem[a] = CW'(3 * a);
        @(posedge clk); #1 pixel_ready = 1'b0;
        bi = issued; bx = xferred;
        start_frame();
        repeat (20) @(negedge clk);
        check("t4_issued_stalled", issued - bi, 4);
        check("t4_valid_held", int'(pixel_valid), 1);
        check("t4_busy", int'(busy), 1);
        @(posedge clk); #1 pixel_ready = 1'b1;
        wait_done(100);
        check("t4_xferred", xferred - bx, 16);
        check("t4_issued_total", issued - bi, 16);

        // Reset mid-sweep, then restart from address 0.
        bx = xferred;
        start_frame();
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (xferred - bx >= 7) begin
                got = 1'b1;
                break;
            end
        end
        check("t5_reached_7", int'(got), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_valid_after_rst", int'(pixel_valid), 0);
        check("t5_busy_after_rst", int'(busy), 0);
        check("t5_rd_after_rst", int'(color_rd), 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        bx = xferred;
        start_frame();
        wait_done(100);
        check("t5_restart_xferred", xferred - bx, 16);

        // frame_start mid-sweep is ignored; one right after frame_done is accepted.
        bx = xferred; bd = done_cnt;
        start_frame();
        repeat (5) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        wait_done(100);
        start_frame();
        wait_done(100);
        repeat (5) @(negedge clk);
        check("t6_xferred", xferred - bx, 32);
        check("t6_done_count", done_cnt - bd, 2);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
